// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, drives the imem read, and fills the IF/ID register. Optional BTB via FETCH_BTB_EN.
// Latency: with zero-wait memory a word requested in cycle n is in IF/ID after edge n; redirect_pc is the address in cycle n+1.
// Backpressure: a stall with a word in flight parks it in a one-entry hold buffer, and no new request issues until the stall drops.
module fetch_unit #(
    parameter int                   WORD_SIZE = 16,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    output logic                 i_mem_read,
    output logic [WORD_SIZE-1:0] i_address,
    input  logic [WORD_SIZE-1:0] i_data,
    input  logic                 i_ready,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [WORD_SIZE-1:0] redirect_pc,
    input  logic                 halt,
    input  logic                 btb_update,
    input  logic [WORD_SIZE-1:0] btb_update_pc,
    input  logic [WORD_SIZE-1:0] btb_update_target,
    input  logic                 btb_update_taken,
    output logic [WORD_SIZE-1:0] ifid_inst,
    output logic [WORD_SIZE-1:0] ifid_pc,
    output logic [WORD_SIZE-1:0] ifid_next_pc,
    output logic                 ifid_valid
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_HOLD,
        S_HALTED
    } state_t;

    localparam logic [WORD_SIZE-1:0] PC_INC = {{(WORD_SIZE-1){1'b0}}, 1'b1};

    state_t                 r_state;
    logic [WORD_SIZE-1:0]   r_pc;
    logic [WORD_SIZE-1:0]   r_hold_inst;
    logic [WORD_SIZE-1:0]   r_hold_pc;
    logic [WORD_SIZE-1:0]   r_hold_next_pc;
    logic [WORD_SIZE-1:0]   r_ifid_inst;
    logic [WORD_SIZE-1:0]   r_ifid_pc;
    logic [WORD_SIZE-1:0]   r_ifid_next_pc;
    logic                   r_ifid_valid;

    state_t                 w_state_nxt;
    logic [WORD_SIZE-1:0]   w_pc_nxt;
    logic [WORD_SIZE-1:0]   w_next_pc;
    logic                   w_ifid_vld_nxt;
    logic                   w_ifid_ld;
    logic                   w_ifid_from_hold;
    logic                   w_hold_ld;

`ifdef FETCH_BTB_EN
    localparam int TAG_W = WORD_SIZE - 2;

    logic [3:0]             r_btb_vld;
    logic [TAG_W-1:0]       r_btb_tag [4];
    logic [WORD_SIZE-1:0]   r_btb_tgt [4];
    logic [1:0]             w_btb_idx;
    logic                   w_btb_hit;

    assign w_btb_idx = r_pc[1:0];
    assign w_btb_hit = r_btb_vld[w_btb_idx] && (r_btb_tag[w_btb_idx] == r_pc[WORD_SIZE-1:2]);
    assign w_next_pc = w_btb_hit ? r_btb_tgt[w_btb_idx] : r_pc + PC_INC;

    // A not-taken update clears the entry, which also drops a stale matching prediction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_btb_vld <= '0;
            for (int i = 0; i < 4; i++) begin
                r_btb_tag[i] <= '0;
                r_btb_tgt[i] <= '0;
            end
        end else if (btb_update) begin
            r_btb_vld[btb_update_pc[1:0]] <= btb_update_taken;
            r_btb_tag[btb_update_pc[1:0]] <= btb_update_pc[WORD_SIZE-1:2];
            r_btb_tgt[btb_update_pc[1:0]] <= btb_update_target;
        end
    end
`else
    logic w_unused_btb;

    assign w_unused_btb = ^{btb_update, btb_update_pc, btb_update_target, btb_update_taken};
    assign w_next_pc    = r_pc + PC_INC;
`endif

    assign i_address    = r_pc;
    assign i_mem_read   = reset_n && (r_state == S_FETCH);
    assign ifid_inst    = r_ifid_inst;
    assign ifid_pc      = r_ifid_pc;
    assign ifid_next_pc = r_ifid_next_pc;
    assign ifid_valid   = r_ifid_valid;

    // Priority: redirect > halt > stall > normal fetch; HALTED is only left by reset.
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_ifid_vld_nxt   = r_ifid_valid;
        w_ifid_ld        = 1'b0;
        w_ifid_from_hold = 1'b0;
        w_hold_ld        = 1'b0;
        if (r_state == S_HALTED) begin
            w_ifid_vld_nxt = 1'b0;
        end else if (redirect) begin
            w_pc_nxt       = redirect_pc;
            w_ifid_vld_nxt = 1'b0;
            w_state_nxt    = S_FETCH;
        end else if (halt && r_ifid_valid) begin
            w_ifid_vld_nxt = 1'b0;
            w_state_nxt    = S_HALTED;
        end else if (r_state == S_HOLD) begin
            if (!stall) begin
                w_ifid_ld        = 1'b1;
                w_ifid_from_hold = 1'b1;
                w_ifid_vld_nxt   = 1'b1;
                w_pc_nxt         = r_hold_next_pc;
                w_state_nxt      = S_FETCH;
            end
        end else if (i_ready) begin
            if (stall) begin
                w_hold_ld   = 1'b1;
                w_state_nxt = S_HOLD;
            end else begin
                w_ifid_ld      = 1'b1;
                w_ifid_vld_nxt = 1'b1;
                w_pc_nxt       = w_next_pc;
            end
        end else if (!stall) begin
            w_ifid_vld_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_FETCH;
            r_pc           <= RESET_PC;
            r_hold_inst    <= '0;
            r_hold_pc      <= '0;
            r_hold_next_pc <= '0;
            r_ifid_inst    <= '0;
            r_ifid_pc      <= '0;
            r_ifid_next_pc <= '0;
            r_ifid_valid   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_ifid_valid <= w_ifid_vld_nxt;
            if (w_hold_ld) begin
                r_hold_inst    <= i_data;
                r_hold_pc      <= r_pc;
                r_hold_next_pc <= w_next_pc;
            end
            if (w_ifid_ld) begin
                if (w_ifid_from_hold) begin
                    r_ifid_inst    <= r_hold_inst;
                    r_ifid_pc      <= r_hold_pc;
                    r_ifid_next_pc <= r_hold_next_pc;
                end else begin
                    r_ifid_inst    <= i_data;
                    r_ifid_pc      <= r_pc;
                    r_ifid_next_pc <= w_next_pc;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed stimulus pushes expected IF/ID words into a queue; a monitor pops and compares on each new IF/ID load.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_mem_read;
    logic [15:0] i_address;
    logic [15:0] i_data;
    logic        i_ready;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halt;
    logic        btb_update;
    logic [15:0] btb_update_pc;
    logic [15:0] btb_update_target;
    logic        btb_update_taken;
    logic [15:0] ifid_inst;
    logic [15:0] ifid_pc;
    logic [15:0] ifid_next_pc;
    logic        ifid_valid;

    int          total = 0;
    int          bad   = 0;
    logic [47:0] exp_q [$];
    logic        m_prev_vld = 1'b0;
    logic [15:0] m_prev_pc  = 16'h0;
    logic [15:0] btb_exp;

    always #5 clk = ~clk;

    // Instruction memory: word at address a is 16'h1000 + a.
    assign i_data = 16'h1000 + i_address;

    fetch_unit #(.WORD_SIZE(16), .RESET_PC(16'h0000)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .i_mem_read       (i_mem_read),
        .i_address        (i_address),
        .i_data           (i_data),
        .i_ready          (i_ready),
        .stall            (stall),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .halt             (halt),
        .btb_update       (btb_update),
        .btb_update_pc    (btb_update_pc),
        .btb_update_target(btb_update_target),
        .btb_update_taken (btb_update_taken),
        .ifid_inst        (ifid_inst),
        .ifid_pc          (ifid_pc),
        .ifid_next_pc     (ifid_next_pc),
        .ifid_valid       (ifid_valid)
    );

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: a new IF/ID word is a valid entry whose PC differs from the previous valid one.
    always @(negedge clk) begin
        if (reset_n && ifid_valid && (!m_prev_vld || ifid_pc != m_prev_pc)) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL ifid_unexpected: got pc %h with no expected entry", ifid_pc);
            end else begin
                chk("ifid_word", {ifid_inst, ifid_pc, ifid_next_pc}, exp_q.pop_front());
            end
        end
        m_prev_vld = ifid_valid;
        m_prev_pc  = ifid_pc;
    end

    // Called at a negedge: checks the request, returns the word this cycle, expects it in IF/ID.
    task automatic step_fetch(input logic [15:0] pc, input logic [15:0] nxt);
        chk("fetch_addr", {32'h0, i_address}, {32'h0, pc});
        chk("fetch_req", {47'h0, i_mem_read}, 48'h1);
        i_ready = 1'b1;
        stall   = 1'b0;
        exp_q.push_back({16'h1000 + pc, pc, nxt});
        @(negedge clk);
        i_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; i_ready = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
        halt = 1'b0; btb_update = 1'b0; btb_update_pc = 16'h0; btb_update_target = 16'h0;
        btb_update_taken = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_mem_read", {47'h0, i_mem_read}, 48'h0);
        chk("rst_ifid", {ifid_valid, ifid_inst, ifid_pc, ifid_next_pc}, 49'h0);
        chk("rst_addr", {32'h0, i_address}, 48'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // Zero-wait streaming from reset.
        for (int a = 0; a < 5; a++) step_fetch(16'(a), 16'(a + 1));

        // Two wait cycles at 0x0005.
        for (int k = 0; k < 2; k++) begin
            chk("wait_addr", {32'h0, i_address}, 48'h0005);
            @(negedge clk);
            chk("wait_bubble", {47'h0, ifid_valid}, 48'h0);
        end
        step_fetch(16'h0005, 16'h0006);
        step_fetch(16'h0006, 16'h0007);

        // Stall as the word at 0x0007 returns.
        i_ready = 1'b1;
        stall   = 1'b1;
        @(negedge clk);
        i_ready = 1'b0;
        chk("hold_no_req", {47'h0, i_mem_read}, 48'h0);
        chk("hold_ifid_kept", {31'h0, ifid_valid, ifid_pc}, {31'h0, 1'b1, 16'h0006});
        @(negedge clk);
        chk("hold_no_req2", {47'h0, i_mem_read}, 48'h0);
        stall = 1'b0;
        exp_q.push_back({16'h1007, 16'h0007, 16'h0008});
        @(negedge clk);
        chk("release_addr", {32'h0, i_address}, 48'h0008);
        chk("release_req", {47'h0, i_mem_read}, 48'h1);

        // Redirect beats stall.
        i_ready = 1'b1; stall = 1'b1; redirect = 1'b1; redirect_pc = 16'h0040;
        @(negedge clk);
        i_ready = 1'b0; stall = 1'b0; redirect = 1'b0;
        chk("redir_bubble", {47'h0, ifid_valid}, 48'h0);
        chk("redir_addr", {32'h0, i_address}, 48'h0040);
        step_fetch(16'h0040, 16'h0041);

        // Halt with a valid HLT in IF/ID; memory keeps answering while halted.
        halt = 1'b1; i_ready = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        for (int k = 0; k < 20; k++) begin
            chk("halted_req", {47'h0, i_mem_read}, 48'h0);
            chk("halted_vld", {47'h0, ifid_valid}, 48'h0);
            chk("halted_pc", {32'h0, i_address}, 48'h0041);
            @(negedge clk);
        end
        i_ready = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        chk("halt_rst_req", {47'h0, i_mem_read}, 48'h0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_halt_addr", {32'h0, i_address}, 48'h0000);
        chk("post_halt_req", {47'h0, i_mem_read}, 48'h1);

        // Halt and redirect together: redirect wins.
        step_fetch(16'h0000, 16'h0001);
        halt = 1'b1; redirect = 1'b1; redirect_pc = 16'h0020; i_ready = 1'b1;
        @(negedge clk);
        halt = 1'b0; redirect = 1'b0; i_ready = 1'b0;
        chk("hr_bubble", {47'h0, ifid_valid}, 48'h0);
        chk("hr_addr", {32'h0, i_address}, 48'h0020);
        step_fetch(16'h0020, 16'h0021);
        step_fetch(16'h0021, 16'h0022);

        // Predictor: 0x0003 taken to 0x0010.
        btb_update = 1'b1; btb_update_pc = 16'h0003; btb_update_target = 16'h0010; btb_update_taken = 1'b1;
        @(negedge clk);
        btb_update = 1'b0;
        redirect = 1'b1; redirect_pc = 16'h0003;
        @(negedge clk);
        redirect = 1'b0;
`ifdef FETCH_BTB_EN
        btb_exp = 16'h0010;
`else
        btb_exp = 16'h0004;
`endif
        step_fetch(16'h0003, btb_exp);
        chk("btb_next_addr", {32'h0, i_address}, {32'h0, btb_exp});
        step_fetch(btb_exp, btb_exp + 16'h0001);

        // PC wrap at the top of the address space.
        redirect = 1'b1; redirect_pc = 16'hFFFF;
        @(negedge clk);
        redirect = 1'b0;
        step_fetch(16'hFFFF, 16'h0000);
        chk("wrap_addr", {32'h0, i_address}, 48'h0000);

        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", {16'h0, 32'(exp_q.size())}, 48'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the pipelined TSC CPU. Sits directly upstream of `control_unit`. Owns the PC and drives the instruction-memory read handshake. Latches each fetched word, with its PC and predicted next PC, into the IF/ID register that feeds decode and `control_unit`. Handles decode stalls, EX-stage redirects (branch, jump, JPR/JRL) and HLT shutdown.

## Interface
Parameters:
- `WORD_SIZE`, 16: instruction, PC and address width.
- `RESET_PC`, 16'h0000: PC value after reset.

Ports:
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- `i_mem_read` out 1: instruction-memory read request.
- `i_address` out 16: fetch address, always equal to `pc`.
- `i_data` in 16: instruction word; valid when `i_ready`=1.
- `i_ready` in 1: memory response strobe, same cycle as `i_data`.
- `stall` in 1: hazard unit holds IF/ID.
- `redirect` in 1: EX resolved a control transfer or misprediction.
- `redirect_pc` in 16: correct next PC.
- `halt` in 1: `halt_id` from `control_unit`; valid IF/ID instruction is HLT.
- `btb_update` in 1: EX writes predictor.
- `btb_update_pc` in 16: PC of the resolved branch or jump.
- `btb_update_target` in 16: resolved target.
- `btb_update_taken` in 1: resolved direction.
- `ifid_inst` out 16: latched instruction.
- `ifid_pc` out 16: PC of `ifid_inst`.
- `ifid_next_pc` out 16: predicted next PC, used for the JAL/JRL link and for misprediction checks.
- `ifid_valid` out 1: IF/ID holds a real instruction.

## Operation
- States: FETCH, HOLD, HALTED.
- Reset values:
  - state FETCH, `pc`=`RESET_PC`.
  - `ifid_valid`=0, `ifid_inst`/`ifid_pc`/`ifid_next_pc`=0.
  - Hold buffer empty, all BTB entries invalid.
- `i_mem_read`=0 while `reset_n`=0.
- `next_pc` (combinational) = BTB target on a hit, else `pc`+1. Addition is modulo 2^16, so 16'hFFFF wraps to 16'h0000.
- FETCH:
  - `i_mem_read`=1.
  - `i_ready`=1, `stall`=0: load IF/ID with {`i_data`, `pc`, `next_pc`}, set `ifid_valid`=1, `pc`<=`next_pc`.
  - `i_ready`=1, `stall`=1: IF/ID unchanged. Capture {`i_data`, `pc`, `next_pc`} in the hold buffer and go to HOLD.
  - `i_ready`=0, `stall`=0: `ifid_valid`<=0 (bubble), `pc` unchanged.
  - `i_ready`=0, `stall`=1: IF/ID and `pc` unchanged.
- HOLD:
  - `i_mem_read`=0; no refetch.
  - When `stall`=0: move buffer to IF/ID, set `ifid_valid`=1, `pc`<=buffered `next_pc`, go to FETCH.
- HALTED:
  - `i_mem_read`=0, `ifid_valid`=0, `pc` frozen.
  - Left only by reset.
- Priority per cycle: `redirect` > `halt` > `stall` > normal.
  - `redirect`=1 in any non-HALTED state: `pc`<=`redirect_pc`, `ifid_valid`<=0 (overrides `stall`), hold buffer discarded, state FETCH. Data returned with `i_ready` in that cycle is dropped.
  - `halt`=1 with `ifid_valid`=1 and no `redirect`: go to HALTED and `ifid_valid`<=0. The HLT already in IF/ID is consumed downstream this cycle.
  - `halt` while `ifid_valid`=0 is ignored.
- The block never issues a request whose response it cannot hold: at most one outstanding fetch plus one buffered word.

## Timing
- Zero-wait memory (`i_ready` same cycle): request in cycle n; IF/ID valid after edge n. Throughput 1 instruction/cycle.
- N wait cycles: `i_address` held stable across them; N bubbles out of IF/ID.
- Redirect penalty: `redirect` in cycle n makes `i_address`=`redirect_pc` in cycle n+1.
- Stall release from HOLD: buffered instruction valid after the first edge with `stall`=0. The next fetch issues in the following cycle.
- BTB lookup is combinational on `pc`. A BTB update written at edge n is visible to lookups from cycle n+1.

## Configuration
- `FETCH_BTB_EN` defined:
  - 4-entry direct-mapped BTB indexed by `pc[1:0]`; each entry holds {valid, tag `pc[15:2]`, target}.
  - Hit = entry valid and tag match.
  - `btb_update` writes entry [`btb_update_pc[1:0]`] with tag and target, valid = `btb_update_taken`.
  - Not-taken update of a matching entry invalidates it.
- Undefined:
  - No BTB storage; `next_pc` = `pc`+1 always.
  - `btb_update*` ports remain present and are ignored.

## Test plan
- Reset, zero-wait memory returning 16'h1000+addr: `ifid_pc` 0,1,2 on consecutive cycles; `ifid_inst`=16'h1000..16'h1002; `ifid_next_pc`=`ifid_pc`+1.
- `pc`=16'h0005, `i_ready` low 2 cycles: `i_address`=16'h0005 held; `ifid_valid`=0 twice; then `ifid_pc`=16'h0005.
- `stall`=1 in the cycle the word at 16'h0007 returns: IF/ID holds the prior instruction; `i_mem_read`=0 during HOLD. After `stall` drops, `ifid_pc`=16'h0007 and the next `i_address`=16'h0008.
- `redirect`=1 with `redirect_pc`=16'h0040 and `stall`=1 simultaneously: `ifid_valid`=0 next cycle; `i_address`=16'h0040.
- `halt` with `ifid_valid`=1:
  - `i_mem_read` stays 0 and `ifid_valid` 0 for 20 cycles; release `reset_n` → `i_address`=`RESET_PC`.
  - Repeat with `redirect` in the same cycle: fetch continues at `redirect_pc`.
- `FETCH_BTB_EN`: update pc 16'h0003 → target 16'h0010, taken, then fetch 16'h0003. Expect `ifid_next_pc`=16'h0010 and next `i_address`=16'h0010. Macro off: 16'h0004.
